mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 Parameter TIMEOUT, default 255, max cycles waiting for mem_ready; 0 disables timeout.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 c_req, c_we  input  1 each  core data port request and write enable.
REQ-008 c_addr  input  AW; c_wdata  input  DW  core address and write data.
REQ-009 c_rdata  output  DW; c_ack  output  1; c_err  output  1  core read data, completion pulse, error flag.
REQ-010 l_req, l_we, l_addr, l_wdata, l_rdata, l_ack, l_err  same directions and widths as the c_* signals, for the loader/debug port.
REQ-011 mem_req, mem_we  output  1 each; mem_addr  output  AW; mem_wdata  output  DW  shared single-port memory request.
REQ-012 mem_rdata  input  DW; mem_ready  input  1  memory read data and completion.
REQ-013 owner  output  2  one-hot current grant: bit0 core, bit1 loader, 00 when idle.

Function
REQ-014 The block SHALL implement states IDLE, BUSY, RESP.
REQ-015 IDLE: with any req high at a clock edge, SHALL select a requester, register its we/addr/wdata and enter BUSY; with no req, SHALL stay in IDLE.
REQ-016 Only one req high: that requester SHALL be granted.
REQ-017 Both req high: the requester not served last SHALL be granted (round-robin); last-served register resets to "loader", so the core wins the first contention.
REQ-018 BUSY: mem_req=1 and mem_we/mem_addr/mem_wdata SHALL equal the latched values, stable for the whole state; owner shows the grant.
REQ-019 Latency: req sampled in IDLE cycle N SHALL give mem_req=1 in cycle N+1.
REQ-020 mem_ready=1 in BUSY cycle M SHALL cause RESP in cycle M+1 with the owner's ack=1 for exactly that cycle, and IDLE in cycle M+2.
REQ-021 On read completion the owner's rdata register SHALL load mem_rdata; writes and the non-owner port SHALL leave rdata unchanged.
REQ-022 Timeout: counter cleared on BUSY entry, incremented each BUSY cycle with mem_ready=0; reaching TIMEOUT (TIMEOUT>0) SHALL enter RESP with ack=1 and err=1, mem_req dropped, owner rdata set to 0 for reads.
REQ-023 mem_ready and timeout in the same cycle: mem_ready SHALL win, err=0.
REQ-024 mem_ready outside BUSY SHALL be ignored.
REQ-025 err SHALL only be high together with the same port's ack.
REQ-026 Requester contract: hold req and its signals stable until ack; a req still high in the IDLE cycle after RESP is a new request.
REQ-027 Non-granted requester's req SHALL remain pending, unaffected, until granted.
REQ-028 mem_req SHALL be 0 in IDLE and RESP.

Reset
REQ-029 At a clock edge with rst=1: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, owner=00, c_ack=l_ack=0, c_err=l_err=0, c_rdata=l_rdata=0, timeout counter 0, last-served=loader.
REQ-030 Reset during BUSY or RESP SHALL abort the transaction with no ack or err issued for it.

Verification
REQ-031 Core read addr 0x10, mem_ready 3 cycles after mem_req, mem_rdata 0xDEADBEEF -> c_ack one cycle, c_rdata=0xDEADBEEF, c_err=0, l_* unchanged.
REQ-032 c_req and l_req both high from reset, both held until ack -> core granted first, then loader; owner 01 then 10; mem_addr follows each latched address.
REQ-033 Loader write 0x5A5A5A5A to 0x40, mem_ready immediate -> mem_we=1 in BUSY, l_ack in RESP, l_rdata unchanged.
REQ-034 TIMEOUT=4, mem_ready never -> mem_req drops after 4 BUSY cycles, c_ack=c_err=1 one cycle, c_rdata=0; mem_ready on cycle 4 instead -> c_err=0.
REQ-035 rst=1 during BUSY -> next cycle all outputs at reset values, no ack; subsequent request completes normally.
REQ-036 mem_ready pulsed in IDLE -> no ack, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter in front of a shared single-port memory. The core port
//   (c_*) and the loader/debug port (l_*) compete for the memory; simultaneous
//   requests alternate round-robin, and the core wins the first contention
//   after reset. Each transaction runs IDLE -> BUSY -> RESP. A BUSY cycle
//   counter aborts a transaction with an error if the memory never answers.
//
// Parameters
//   AW       address width
//   DW       data width
//   TIMEOUT  BUSY cycles without mem_ready before aborting (0 = never)
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata core request, write enable, address, write data
//   c_rdata/c_ack/c_err       core read data, one-cycle completion, error flag
//   l_*                       same set of signals for the loader/debug port
//   mem_req/mem_we/mem_addr/mem_wdata  request to the shared memory
//   mem_rdata/mem_ready       memory read data and completion strobe
//   owner                     one-hot grant (bit0 core, bit1 loader), 00 idle
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  output logic          c_err,

  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic [DW-1:0] l_rdata,
  output logic          l_ack,
  output logic          l_err,

  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,

  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter is wide enough to hold TIMEOUT-1; one bit when timeout is off.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] to_cnt;
  logic          last_loader;  // 1: loader was served most recently
  logic          pick_loader;
  logic          timeout_hit;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here by construction); a missing default would infer a latch.
  always_comb begin
    pick_loader = 1'b0;
    timeout_hit = 1'b0;
    // Loader wins when alone, or in contention when the core was served last.
    pick_loader = l_req && (!c_req || !last_loader);
    // This BUSY cycle would be the TIMEOUT-th one without mem_ready.
    timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values; blocking here would create
  // order-dependent simulation and sim/synth mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      owner       <= 2'b00;
      c_ack       <= 1'b0;
      c_err       <= 1'b0;
      c_rdata     <= '0;
      l_ack       <= 1'b0;
      l_err       <= 1'b0;
      l_rdata     <= '0;
      to_cnt      <= '0;
      last_loader <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (c_req || l_req) begin
            state       <= BUSY;
            mem_req     <= 1'b1;
            to_cnt      <= '0;
            last_loader <= pick_loader;
            owner       <= pick_loader ? 2'b10 : 2'b01;
            mem_we      <= pick_loader ? l_we    : c_we;
            mem_addr    <= pick_loader ? l_addr  : c_addr;
            mem_wdata   <= pick_loader ? l_wdata : c_wdata;
          end
        end

        BUSY: begin
          // mem_ready takes precedence over a timeout in the same cycle.
          if (mem_ready) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (owner[0]) begin
              c_ack <= 1'b1;
              if (!mem_we) c_rdata <= mem_rdata;
            end else begin
              l_ack <= 1'b1;
              if (!mem_we) l_rdata <= mem_rdata;
            end
          end else if (timeout_hit) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (owner[0]) begin
              c_ack <= 1'b1;
              c_err <= 1'b1;
              if (!mem_we) c_rdata <= '0;
            end else begin
              l_ack <= 1'b1;
              l_err <= 1'b1;
              if (!mem_we) l_rdata <= '0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
          owner <= 2'b00;
          c_ack <= 1'b0;
          c_err <= 1'b0;
          l_ack <= 1'b0;
          l_err <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with TIMEOUT=4. Inputs are driven and
//   outputs sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, l_req, l_we;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] c_wdata, l_wdata;
  logic [DW-1:0] c_rdata, l_rdata;
  logic          c_ack, c_err, l_ack, l_err;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    owner;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .c_ack     (c_ack),
    .c_err     (c_err),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_rdata   (l_rdata),
    .l_ack     (l_ack),
    .l_err     (l_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    mem_ready = 0; mem_rdata = '0;

    // Both ports request while still in reset and hold until acked.
    c_addr = 32'h100;
    l_req = 1; l_we = 1; l_addr = 32'h200; l_wdata = 32'h11;
    c_req = 1;
    step();
    step();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_owner", owner, 2'b00);
    check("rst_c_ack", c_ack, 0);
    check("rst_l_ack", l_ack, 0);
    check("rst_c_err", c_err, 0);
    check("rst_l_err", l_err, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_l_rdata", l_rdata, 0);

    // Contention: core first, then loader.
    rst = 0;
    step();
    check("rr1_mem_req", mem_req, 1);
    check("rr1_owner", owner, 2'b01);
    check("rr1_mem_addr", mem_addr, 32'h100);
    check("rr1_mem_we", mem_we, 0);
    mem_ready = 1; mem_rdata = 32'hAAAA0001;
    step();
    check("rr1_c_ack", c_ack, 1);
    check("rr1_c_rdata", c_rdata, 32'hAAAA0001);
    check("rr1_l_ack", l_ack, 0);
    check("rr1_resp_mem_req", mem_req, 0);
    mem_ready = 0; c_req = 0;
    step();
    check("rr1_idle_ack", c_ack, 0);
    check("rr1_idle_owner", owner, 2'b00);
    check("rr1_idle_mem_req", mem_req, 0);
    step();
    check("rr2_owner", owner, 2'b10);
    check("rr2_mem_addr", mem_addr, 32'h200);
    check("rr2_mem_we", mem_we, 1);
    check("rr2_mem_wdata", mem_wdata, 32'h11);
    mem_ready = 1;
    step();
    check("rr2_l_ack", l_ack, 1);
    check("rr2_l_rdata", l_rdata, 0);
    check("rr2_c_rdata", c_rdata, 32'hAAAA0001);
    mem_ready = 0; l_req = 0; l_we = 0;
    step();

    // mem_ready in IDLE is ignored.
    mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
    step();
    check("idle_rdy_c_ack", c_ack, 0);
    check("idle_rdy_l_ack", l_ack, 0);
    check("idle_rdy_mem_req", mem_req, 0);
    step();
    check("idle_rdy_owner", owner, 2'b00);
    check("idle_rdy_c_rdata", c_rdata, 32'hAAAA0001);
    mem_ready = 0;

    // Core read of 0x10; memory answers in the third BUSY cycle.
    c_req = 1; c_we = 0; c_addr = 32'h10;
    step();
    check("rd_mem_req", mem_req, 1);
    check("rd_mem_addr", mem_addr, 32'h10);
    step();
    step();
    check("rd_busy3_mem_req", mem_req, 1);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    step();
    check("rd_c_ack", c_ack, 1);
    check("rd_c_err", c_err, 0);
    check("rd_c_rdata", c_rdata, 32'hDEADBEEF);
    check("rd_l_ack", l_ack, 0);
    check("rd_l_rdata", l_rdata, 0);
    mem_ready = 0; c_req = 0;
    step();
    check("rd_ack_pulse", c_ack, 0);

    // Loader write of 0x5A5A5A5A to 0x40 with immediate mem_ready.
    l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'h5A5A5A5A;
    step();
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 32'h40);
    check("wr_mem_wdata", mem_wdata, 32'h5A5A5A5A);
    check("wr_owner", owner, 2'b10);
    mem_ready = 1; mem_rdata = 32'h12345678;
    step();
    check("wr_l_ack", l_ack, 1);
    check("wr_l_err", l_err, 0);
    check("wr_l_rdata", l_rdata, 0);
    check("wr_c_rdata", c_rdata, 32'hDEADBEEF);
    mem_ready = 0; l_req = 0; l_we = 0;
    step();

    // Timeout: four BUSY cycles, then error response.
    c_req = 1; c_we = 0; c_addr = 32'h80;
    step();
    check("to_busy1", mem_req, 1);
    step();
    step();
    step();
    check("to_busy4", mem_req, 1);
    step();
    check("to_mem_req", mem_req, 0);
    check("to_c_ack", c_ack, 1);
    check("to_c_err", c_err, 1);
    check("to_c_rdata", c_rdata, 0);
    check("to_l_err", l_err, 0);
    c_req = 0;
    step();
    check("to_idle_err", c_err, 0);

    // mem_ready on the fourth BUSY cycle beats the timeout.
    c_req = 1; c_addr = 32'h84;
    step();
    step();
    step();
    step();
    mem_ready = 1; mem_rdata = 32'hCAFE0004;
    step();
    check("tr_c_ack", c_ack, 1);
    check("tr_c_err", c_err, 0);
    check("tr_c_rdata", c_rdata, 32'hCAFE0004);
    mem_ready = 0; c_req = 0;
    step();

    // Contention after the core was served last: loader wins this time.
    c_req = 1; c_addr = 32'h300;
    l_req = 1; l_we = 0; l_addr = 32'h400;
    step();
    check("rr3_owner", owner, 2'b10);
    check("rr3_mem_addr", mem_addr, 32'h400);
    mem_ready = 1; mem_rdata = 32'h44;
    step();
    check("rr3_l_rdata", l_rdata, 32'h44);
    mem_ready = 0; l_req = 0;
    step();
    step();
    check("rr4_owner", owner, 2'b01);
    check("rr4_mem_addr", mem_addr, 32'h300);
    mem_ready = 1; mem_rdata = 32'h33;
    step();
    check("rr4_c_rdata", c_rdata, 32'h33);
    mem_ready = 0; c_req = 0;
    step();

    // Reset during BUSY aborts silently; the held request then completes.
    c_req = 1; c_addr = 32'h90;
    step();
    check("ab_busy", mem_req, 1);
    rst = 1;
    step();
    check("ab_mem_req", mem_req, 0);
    check("ab_owner", owner, 2'b00);
    check("ab_mem_addr", mem_addr, 0);
    check("ab_c_ack", c_ack, 0);
    check("ab_c_err", c_err, 0);
    check("ab_c_rdata", c_rdata, 0);
    check("ab_l_rdata", l_rdata, 0);
    rst = 0;
    step();
    check("ab2_mem_req", mem_req, 1);
    check("ab2_mem_addr", mem_addr, 32'h90);
    check("ab2_owner", owner, 2'b01);
    mem_ready = 1; mem_rdata = 32'h55;
    step();
    check("ab2_c_ack", c_ack, 1);
    check("ab2_c_rdata", c_rdata, 32'h55);
    mem_ready = 0; c_req = 0;
    step();
    check("ab2_idle_ack", c_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
